// File: rtl/pair_serial_mag_cmp_if.sv
`default_nettype none
// ============================================================================
// Module   : pair_serial_mag_cmp_if
// Purpose  : Request/result bundle for the pair-serial magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
interface pair_serial_mag_cmp_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done_tick;
    logic         agtb;
    logic         aeqb;
    logic         altb;

    modport master (
        output start, a, b,
        input  ready, done_tick, agtb, aeqb, altb
    );

    modport slave (
        input  start, a, b,
        output ready, done_tick, agtb, aeqb, altb
    );
endinterface
`default_nettype wire

// File: rtl/pair_serial_mag_cmp.sv
`default_nettype none
// ============================================================================
// Module   : pair_serial_mag_cmp
// Purpose  : Bit-serial unsigned comparator, two bits per clock, MSB pair first.
// Revision : 1.0 - initial release
// ============================================================================
module pair_serial_mag_cmp #(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    pair_serial_mag_cmp_if.slave  bus
);

    generate
        if ((W < 2) || ((W % 2) != 0)) begin : g_bad_width
            $error("pair_serial_mag_cmp: W must be even and >= 2");
        end
    endgenerate

    localparam int               CNT_W    = (W / 2 > 1) ? $clog2(W / 2) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               agtb_q, agtb_d;
    logic               aeqb_q, aeqb_d;
    logic               altb_q, altb_d;

    logic [1:0]         w_pa;
    logic [1:0]         w_pb;
    logic               w_gt2;
    logic               w_lt2;

    // 2-bit greater-than primitive in sum-of-products form, applied both ways.
    assign w_pa  = a_q[W-1 -: 2];
    assign w_pb  = b_q[W-1 -: 2];
    assign w_gt2 = (w_pa[1] & ~w_pb[1])
                 | (w_pa[1] &  w_pa[0] & ~w_pb[0])
                 | (w_pa[0] & ~w_pb[1] & ~w_pb[0]);
    assign w_lt2 = (w_pb[1] & ~w_pa[1])
                 | (w_pb[1] &  w_pb[0] & ~w_pa[0])
                 | (w_pb[0] & ~w_pa[1] & ~w_pa[0]);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        agtb_d  = agtb_q;
        aeqb_d  = aeqb_q;
        altb_d  = altb_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cnt_d   = CNT_INIT;
                    agtb_d  = 1'b0;
                    aeqb_d  = 1'b0;
                    altb_d  = 1'b0;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (w_gt2) begin
                    agtb_d  = 1'b1;
                    state_d = S_DONE;
                end else if (w_lt2) begin
                    altb_d  = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    aeqb_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    a_d   = a_q << 2;
                    b_d   = b_q << 2;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            agtb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            altb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            agtb_q  <= agtb_d;
            aeqb_q  <= aeqb_d;
            altb_q  <= altb_d;
        end
    end

    assign bus.ready     = (state_q == S_IDLE);
    assign bus.done_tick = (state_q == S_DONE);
    assign bus.agtb      = agtb_q;
    assign bus.aeqb      = aeqb_q;
    assign bus.altb      = altb_q;

endmodule
`default_nettype wire
